// File: rtl/tinysnn_pkg.sv
// Shared definitions for the tinysnn scheduler slice.
//   - default parameter values for the neuron array
//   - membrane saturation limits for the default potential width
//   - FSM state encoding
package tinysnn_pkg;

    localparam int N_NEURON_DEF = 4;
    localparam int N_INPUT_DEF  = 8;
    localparam int W_WIDTH_DEF  = 4;
    localparam int V_WIDTH_DEF  = 8;

    localparam int CFG_ADDR_W   = 5;   // {neuron[1:0], input[2:0]}
    localparam int LEAK_W       = 4;

    localparam int V_MAX_DEF    = 127;
    localparam int V_MIN_DEF    = -128;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAK  = 3'd1,
        ST_ACCUM = 3'd2,
        ST_FIRE  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/tinysnn_if.sv
// Host-side bundle of the tinysnn scheduler: timestep request, spike inputs,
// weight configuration, neuron parameters and timestep results.
//   master : host (drives tick/spike_in/cfg_*/threshold/leak)
//   slave  : scheduler (drives spike_out/busy/done/overrun)
interface tinysnn_if
    import tinysnn_pkg::*;
#(
    parameter int N_NEURON = N_NEURON_DEF,
    parameter int N_INPUT  = N_INPUT_DEF,
    parameter int W_WIDTH  = W_WIDTH_DEF,
    parameter int V_WIDTH  = V_WIDTH_DEF
);

    logic                       tick;
    logic [N_INPUT-1:0]         spike_in;
    logic                       cfg_we;
    logic [CFG_ADDR_W-1:0]      cfg_addr;
    logic [W_WIDTH-1:0]         cfg_wdata;
    logic signed [V_WIDTH-1:0]  threshold;
    logic [LEAK_W-1:0]          leak;
    logic [N_NEURON-1:0]        spike_out;
    logic                       busy;
    logic                       done;
    logic                       overrun;

    modport master (
        output tick, spike_in, cfg_we, cfg_addr, cfg_wdata, threshold, leak,
        input  spike_out, busy, done, overrun
    );

    modport slave (
        input  tick, spike_in, cfg_we, cfg_addr, cfg_wdata, threshold, leak,
        output spike_out, busy, done, overrun
    );

endinterface

// File: rtl/tinysnn_sat_add.sv
// Signed saturating adder shared by the leak and accumulate steps.
//   a, b : V_WIDTH-bit signed operands
//   y    : a + b clipped to [SAT_MIN, SAT_MAX]
module tinysnn_sat_add
    import tinysnn_pkg::*;
#(
    parameter int V_WIDTH = V_WIDTH_DEF,
    parameter int SAT_MAX = V_MAX_DEF,
    parameter int SAT_MIN = V_MIN_DEF
) (
    input  logic signed [V_WIDTH-1:0] a,
    input  logic signed [V_WIDTH-1:0] b,
    output logic signed [V_WIDTH-1:0] y
);

    // One guard bit is enough: the sum of two in-range operands cannot
    // exceed twice the range.
    logic signed [V_WIDTH:0] sum;

    assign sum = {a[V_WIDTH-1], a} + {b[V_WIDTH-1], b};

    always_comb begin
        if (sum > SAT_MAX) begin
            y = V_WIDTH'(SAT_MAX);
        end else if (sum < SAT_MIN) begin
            y = V_WIDTH'(SAT_MIN);
        end else begin
            y = sum[V_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/tinysnn_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler. One tick runs a full
// timestep: every neuron in turn is leaked, integrates its weighted input
// spikes one input per cycle, and is compared against the threshold.
//   clk, rst_n : clock, async active-low reset
//   ena        : global enable, low freezes everything
//   bus        : tinysnn_if slave (tick/spike_in/cfg/threshold/leak in,
//                spike_out/busy/done/overrun out)
//
// state | meaning
// IDLE  | waiting for tick; weight writes accepted
// LEAK  | acc = sat(V[n] - leak)
// ACCUM | acc = sat(acc + W[n][i]) for latched spike[i], one input per cycle
// FIRE  | threshold compare, update V[n] and fire[n], next neuron or DONE
// DONE  | spike_out valid, done pulse
module tinysnn_scheduler
    import tinysnn_pkg::*;
#(
    parameter int N_NEURON = N_NEURON_DEF,
    parameter int N_INPUT  = N_INPUT_DEF,
    parameter int W_WIDTH  = W_WIDTH_DEF,
    parameter int V_WIDTH  = V_WIDTH_DEF
) (
    input logic      clk,
    input logic      rst_n,
    input logic      ena,
    tinysnn_if.slave bus
);

    localparam logic [2:0] IDLE  = ST_IDLE;
    localparam logic [2:0] LEAK  = ST_LEAK;
    localparam logic [2:0] ACCUM = ST_ACCUM;
    localparam logic [2:0] FIRE  = ST_FIRE;
    localparam logic [2:0] DONE  = ST_DONE;

    localparam int NW = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
    localparam int IW = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;
    localparam logic [NW-1:0] N_LAST = NW'(N_NEURON - 1);
    localparam logic [IW-1:0] I_LAST = IW'(N_INPUT - 1);
    localparam int V_MAX = 2 ** (V_WIDTH - 1) - 1;
    localparam int V_MIN = -(2 ** (V_WIDTH - 1));

    logic [2:0]                state;
    logic [NW-1:0]             n;
    logic [IW-1:0]             i;
    logic signed [V_WIDTH-1:0] acc;
    logic signed [V_WIDTH-1:0] v_mem [N_NEURON];
    logic signed [W_WIDTH-1:0] w_mem [N_NEURON][N_INPUT];
    logic [N_INPUT-1:0]        spike_lat;
    logic [N_NEURON-1:0]       fire;
    logic [N_NEURON-1:0]       fire_nxt;
    logic [N_NEURON-1:0]       spike_out_q;
    logic                      overrun_q;

    logic signed [V_WIDTH-1:0] sat_a;
    logic signed [V_WIDTH-1:0] sat_b;
    logic signed [V_WIDTH-1:0] sat_y;
    logic signed [V_WIDTH-1:0] leak_ext;
    logic signed [V_WIDTH-1:0] w_ext;
    logic signed [W_WIDTH-1:0] w_cur;
    logic                      fires;

    assign w_cur    = w_mem[n][i];
    assign w_ext    = {{(V_WIDTH-W_WIDTH){w_cur[W_WIDTH-1]}}, w_cur};
    assign leak_ext = {{(V_WIDTH-LEAK_W){1'b0}}, bus.leak};
    assign fires    = (acc >= bus.threshold);

    // LEAK and ACCUM share one adder; outside those states the operands
    // are irrelevant, so acc + 0 is presented.
    always_comb begin
        sat_a = acc;
        sat_b = '0;
        if (state == LEAK) begin
            sat_a = v_mem[n];
            sat_b = -leak_ext;
        end else if (state == ACCUM && spike_lat[i]) begin
            sat_b = w_ext;
        end
    end

    always_comb begin
        fire_nxt    = fire;
        fire_nxt[n] = fires;
    end

    tinysnn_sat_add #(
        .V_WIDTH (V_WIDTH),
        .SAT_MAX (V_MAX),
        .SAT_MIN (V_MIN)
    ) u_sat_add (
        .a (sat_a),
        .b (sat_b),
        .y (sat_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            n           <= '0;
            i           <= '0;
            acc         <= '0;
            spike_lat   <= '0;
            fire        <= '0;
            spike_out_q <= '0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < N_NEURON; k++) begin
                v_mem[k] <= '0;
            end
        end else if (ena) begin
            // DONE counts as busy, so a tick there is also an overrun.
            if (bus.tick && state != IDLE) begin
                overrun_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.tick) begin
                        spike_lat <= bus.spike_in;
                        n         <= '0;
                        state     <= LEAK;
                    end
                end
                LEAK: begin
                    acc   <= sat_y;
                    i     <= '0;
                    state <= ACCUM;
                end
                ACCUM: begin
                    acc <= sat_y;
                    if (i == I_LAST) begin
                        state <= FIRE;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                FIRE: begin
                    fire     <= fire_nxt;
                    v_mem[n] <= fires ? '0 : acc;
                    if (n == N_LAST) begin
                        // Loaded on entry to DONE so spike_out is valid
                        // in the same cycle as the done pulse.
                        spike_out_q <= fire_nxt;
                        state       <= DONE;
                    end else begin
                        n     <= n + 1'b1;
                        state <= LEAK;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Weight file. Writes land only in IDLE, which also lets a write
    // issued alongside a tick be used by that same timestep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < N_NEURON; a++) begin
                for (int b = 0; b < N_INPUT; b++) begin
                    w_mem[a][b] <= '0;
                end
            end
        end else if (ena && bus.cfg_we && state == IDLE) begin
            w_mem[bus.cfg_addr[4:3]][bus.cfg_addr[2:0]] <= bus.cfg_wdata;
        end
    end

    assign bus.spike_out = spike_out_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_tinysnn_scheduler.sv
module tb_tinysnn_scheduler;
    import tinysnn_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    tinysnn_if bus ();

    tinysnn_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    int cyc_now;
    int done_cnt;
    int done_cyc;
    logic [3:0] exp_q [$];
    logic [3:0] got_q [$];

    int v_m [4];
    int w_m [4][8];
    int thr;
    int lk;

    // ---------------- reference model ----------------
    function automatic int clip(input int x);
        if (x > V_MAX_DEF) return V_MAX_DEF;
        if (x < V_MIN_DEF) return V_MIN_DEF;
        return x;
    endfunction

    task automatic model_step(input logic [7:0] sp, output logic [3:0] f);
        int a;
        f = '0;
        for (int nn = 0; nn < 4; nn++) begin
            a = clip(v_m[nn] - lk);
            for (int ii = 0; ii < 8; ii++) begin
                if (sp[ii]) a = clip(a + w_m[nn][ii]);
            end
            if (a >= thr) begin
                f[nn]   = 1'b1;
                v_m[nn] = 0;
            end else begin
                v_m[nn] = a;
            end
        end
    endtask

    task automatic model_clear();
        for (int nn = 0; nn < 4; nn++) begin
            v_m[nn] = 0;
            for (int ii = 0; ii < 8; ii++) w_m[nn][ii] = 0;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- stimulus / monitor ----------------
    task automatic set_params(input int t, input int l);
        thr           = t;
        lk            = l;
        bus.threshold = 8'(t);
        bus.leak      = 4'(l);
    endtask

    task automatic sample_now();
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (done_cnt == 1) done_cyc = cyc_now;
            got_q.push_back(bus.spike_out);
        end
    endtask

    task automatic run_until(input int stop, input bit stop_on_done);
        while (cyc_now < stop && !(stop_on_done && done_cnt > 0)) begin
            @(negedge clk);
            cyc_now++;
            sample_now();
        end
    endtask

    task automatic cfg_write(input int nn, input int ii, input int w);
        @(negedge clk);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 5'(nn * 8 + ii);
        bus.cfg_wdata = 4'(w);
        w_m[nn][ii]   = w;
        @(negedge clk);
        bus.cfg_we    = 1'b0;
    endtask

    // Drives tick at the next falling edge; cycle 1 is the sample point
    // right after the tick-sampling rising edge.
    task automatic start_tick(input logic [7:0] sp, input bit cfg_en,
                              input logic [4:0] addr, input int data);
        logic [3:0] e;
        @(negedge clk);
        bus.tick     = 1'b1;
        bus.spike_in = sp;
        if (cfg_en) begin
            bus.cfg_we    = 1'b1;
            bus.cfg_addr  = addr;
            bus.cfg_wdata = 4'(data);
            w_m[addr[4:3]][addr[2:0]] = data;
        end
        model_step(sp, e);
        exp_q.push_back(e);
        @(negedge clk);
        bus.tick   = 1'b0;
        bus.cfg_we = 1'b0;
        cyc_now    = 1;
        done_cnt   = 0;
        done_cyc   = -1;
        sample_now();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        ena   = 1'b1;
        bus.tick = 1'b0;
        bus.spike_in = '0;
        bus.cfg_we = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_wdata = '0;
        set_params(10, 0);
        model_clear();
        #12;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
        n_total++; if (bus.spike_out !== 4'b0000) $display("FAIL reset_spike_out: got %b want 0000", bus.spike_out); else n_pass++;
        n_total++; if (bus.overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", bus.overrun); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_idle: busy got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_basic();
        logic [3:0] want [2] = '{4'b0000, 4'b0001};
        logic [3:0] e, g;
        cfg_write(0, 0, 7);
        set_params(10, 0);
        for (int k = 0; k < 2; k++) begin
            start_tick(8'h01, 1'b0, 5'd0, 0);
            run_until(80, 1'b1);
            n_total++; if (done_cyc !== 41) $display("FAIL basic_latency: got %0d want 41", done_cyc); else n_pass++;
            e = exp_q.pop_front();
            n_total++;
            if (got_q.size() == 0) $display("FAIL basic_sb: no done, want %b", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL basic_sb: got %b want %b", g, e); else n_pass++;
                n_total++; if (g !== want[k]) $display("FAIL basic_const: got %b want %b", g, want[k]); else n_pass++;
            end
        end
        @(negedge clk);
        n_total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL basic_pulse: done %b busy %b want 0 0", bus.done, bus.busy); else n_pass++;
    endtask

    task automatic test_sat_pos();
        logic [3:0] want [3] = '{4'b0000, 4'b0000, 4'b0010};
        logic [3:0] e, g;
        for (int ii = 0; ii < 8; ii++) cfg_write(1, ii, 7);
        set_params(127, 0);
        for (int k = 0; k < 3; k++) begin
            start_tick(8'hFF, 1'b0, 5'd0, 0);
            run_until(80, 1'b1);
            n_total++; if (done_cyc !== 41) $display("FAIL satpos_latency: got %0d want 41", done_cyc); else n_pass++;
            e = exp_q.pop_front();
            n_total++;
            if (got_q.size() == 0) $display("FAIL satpos_sb: no done, want %b", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL satpos_sb: got %b want %b", g, e); else n_pass++;
                n_total++; if (g !== want[k]) $display("FAIL satpos_const: got %b want %b", g, want[k]); else n_pass++;
            end
        end
    endtask

    task automatic test_sat_neg();
        logic [7:0] sp   [5] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
        int         th   [5] = '{127, 127, 127, -127, -128};
        int         lv   [5] = '{15, 15, 15, 0, 0};
        logic [3:0] want [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b1011, 4'b1111};
        logic [3:0] e, g;
        for (int ii = 0; ii < 8; ii++) cfg_write(2, ii, -8);
        for (int k = 0; k < 5; k++) begin
            set_params(th[k], lv[k]);
            start_tick(sp[k], 1'b0, 5'd0, 0);
            run_until(80, 1'b1);
            e = exp_q.pop_front();
            n_total++;
            if (got_q.size() == 0) $display("FAIL satneg_sb: no done, want %b", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL satneg_sb: step %0d got %b want %b", k, g, e); else n_pass++;
                n_total++; if (g !== want[k]) $display("FAIL satneg_const: step %0d got %b want %b", k, g, want[k]); else n_pass++;
            end
        end
    endtask

    task automatic test_done_tick();
        logic [3:0] e, g;
        apply_reset();
        set_params(10, 0);
        start_tick(8'h00, 1'b0, 5'd0, 0);
        run_until(80, 1'b1);
        n_total++; if (done_cyc !== 41) $display("FAIL donetick_latency: got %0d want 41", done_cyc); else n_pass++;
        e = exp_q.pop_front();
        n_total++;
        if (got_q.size() == 0) $display("FAIL donetick_sb: no done, want %b", e);
        else begin
            g = got_q.pop_front();
            if (g !== e) $display("FAIL donetick_sb: got %b want %b", g, e); else n_pass++;
        end
        n_total++; if (bus.overrun !== 1'b0) $display("FAIL donetick_pre_overrun: got %b want 0", bus.overrun); else n_pass++;
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL donetick_ignored: busy got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.overrun !== 1'b1) $display("FAIL donetick_overrun: got %b want 1", bus.overrun); else n_pass++;
    endtask

    task automatic test_overrun();
        logic [3:0] e, g;
        apply_reset();
        set_params(10, 0);
        start_tick(8'h01, 1'b0, 5'd0, 0);
        run_until(20, 1'b0);
        n_total++; if (bus.overrun !== 1'b0) $display("FAIL overrun_pre: got %b want 0", bus.overrun); else n_pass++;
        bus.tick = 1'b1;
        run_until(21, 1'b0);
        bus.tick = 1'b0;
        run_until(70, 1'b0);
        n_total++; if (done_cnt !== 1) $display("FAIL overrun_done_count: got %0d want 1", done_cnt); else n_pass++;
        n_total++; if (done_cyc !== 41) $display("FAIL overrun_latency: got %0d want 41", done_cyc); else n_pass++;
        n_total++; if (bus.overrun !== 1'b1) $display("FAIL overrun_flag: got %b want 1", bus.overrun); else n_pass++;
        e = exp_q.pop_front();
        n_total++;
        if (got_q.size() == 0) $display("FAIL overrun_sb: no done, want %b", e);
        else begin
            g = got_q.pop_front();
            if (g !== e) $display("FAIL overrun_sb: got %b want %b", g, e); else n_pass++;
        end
        got_q.delete();
    endtask

    task automatic test_cfg_busy();
        logic [3:0] want [3] = '{4'b0000, 4'b0000, 4'b1000};
        logic [3:0] e, g;
        set_params(5, 0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) start_tick(8'h02, 1'b1, 5'd25, 5);
            else        start_tick(8'h01, 1'b0, 5'd0, 0);
            if (k == 0) begin
                run_until(5, 1'b0);
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = 5'd24;
                bus.cfg_wdata = 4'd7;
                run_until(6, 1'b0);
                bus.cfg_we    = 1'b0;
            end
            run_until(80, 1'b1);
            n_total++; if (done_cyc !== 41) $display("FAIL cfg_latency: step %0d got %0d want 41", k, done_cyc); else n_pass++;
            e = exp_q.pop_front();
            n_total++;
            if (got_q.size() == 0) $display("FAIL cfg_sb: no done, want %b", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL cfg_sb: step %0d got %b want %b", k, g, e); else n_pass++;
                n_total++; if (g !== want[k]) $display("FAIL cfg_const: step %0d got %b want %b", k, g, want[k]); else n_pass++;
            end
        end
    endtask

    task automatic test_ena_pause();
        logic [3:0] e, g;
        set_params(5, 0);
        start_tick(8'h02, 1'b0, 5'd0, 0);
        run_until(10, 1'b0);
        ena = 1'b0;
        run_until(20, 1'b0);
        n_total++; if (bus.busy !== 1'b1 || done_cnt !== 0)
            $display("FAIL ena_hold: busy %b dones %0d want 1 0", bus.busy, done_cnt); else n_pass++;
        ena = 1'b1;
        run_until(100, 1'b1);
        n_total++; if (done_cyc !== 51) $display("FAIL ena_latency: got %0d want 51", done_cyc); else n_pass++;
        e = exp_q.pop_front();
        n_total++;
        if (got_q.size() == 0) $display("FAIL ena_sb: no done, want %b", e);
        else begin
            g = got_q.pop_front();
            if (g !== e) $display("FAIL ena_sb: got %b want %b", g, e); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e, g;
        start_tick(8'h02, 1'b0, 5'd0, 0);
        run_until(15, 1'b0);
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", bus.done); else n_pass++;
        n_total++; if (bus.spike_out !== 4'b0000) $display("FAIL rstmid_spike_out: got %b want 0000", bus.spike_out); else n_pass++;
        n_total++; if (bus.overrun !== 1'b0) $display("FAIL rstmid_overrun: got %b want 0", bus.overrun); else n_pass++;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL rstmid_idle: done %b busy %b want 0 0", bus.done, bus.busy); else n_pass++;
        start_tick(8'h02, 1'b0, 5'd0, 0);
        run_until(80, 1'b1);
        n_total++; if (done_cyc !== 41) $display("FAIL rstmid_latency: got %0d want 41", done_cyc); else n_pass++;
        e = exp_q.pop_front();
        n_total++;
        if (got_q.size() == 0) $display("FAIL rstmid_sb: no done, want %b", e);
        else begin
            g = got_q.pop_front();
            if (g !== e) $display("FAIL rstmid_sb: got %b want %b", g, e); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat_pos();
        test_sat_neg();
        test_done_tick();
        test_overrun();
        test_cfg_busy();
        test_ena_pause();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
